// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman match controller.
package hangman_pkg;

  localparam int unsigned LETTER_W    = 5;
  localparam int unsigned LETTER_MAX  = 26;
  localparam int unsigned SCORE_W     = 4;
  localparam int unsigned WORD_PULSES = 7;
  localparam logic [LETTER_W-1:0] FORCED_MISS = 5'b11111;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SET,
    GUESS,
    RESULT,
    DONE
  } state_e;

  // One letter request heading for the game core.
  typedef struct packed {
    logic                vld;
    logic [LETTER_W-1:0] letter;
  } fwd_t;

  function automatic logic letter_ok(input logic [LETTER_W-1:0] l);
    return (l != '0) && (l <= LETTER_W'(LETTER_MAX));
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

  // 01 = p0 ahead, 10 = p1 ahead, 11 = level.
  function automatic logic [1:0] match_winner(input logic [SCORE_W-1:0] s0,
                                               input logic [SCORE_W-1:0] s1);
    if (s0 > s1)      return 2'b01;
    else if (s1 > s0) return 2'b10;
    else              return 2'b11;
  endfunction

endpackage

// File: rtl/hangman_match_ctrl_if.sv
// Controller <-> game-core link: core reset, letter/confirm forward, result levels.
interface hangman_match_ctrl_if;
  import hangman_pkg::*;

  logic                core_resetn;
  logic [LETTER_W-1:0] core_letter;
  logic                core_confirm;
  logic                core_win;
  logic                core_lose;

  modport master (
    output core_resetn, core_letter, core_confirm,
    input  core_win, core_lose
  );

  modport slave (
    input  core_resetn, core_letter, core_confirm,
    output core_win, core_lose
  );
endinterface

// File: rtl/hangman_edge_sync.sv
// Two-flop synchronizer on an asynchronous button level plus rising-edge detect.
module hangman_edge_sync (
  input  logic clock,
  input  logic Resetn,
  input  logic async_in,
  output logic rise_c
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/hangman_match_ctrl.sv
// Two-player hangman match sequencer: word setting, guessing, scoring over ROUNDS rounds.
// Optional guess-idle forced miss is built when HANGMAN_TIMEOUT_EN is defined.
module hangman_match_ctrl
  import hangman_pkg::*;
#(
  parameter int unsigned ROUNDS         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                 clock,
  input  logic                 Resetn,
  input  logic [LETTER_W-1:0]  p0_letter,
  input  logic                 p0_confirm,
  input  logic [LETTER_W-1:0]  p1_letter,
  input  logic                 p1_confirm,
  hangman_match_ctrl_if.master core,
  output logic                 setter,
  output logic [SCORE_W-1:0]   score0,
  output logic [SCORE_W-1:0]   score1,
  output logic [SCORE_W-1:0]   round,
  output logic                 match_done,
  output logic [1:0]           winner
);

  logic                p0_rise_c, p1_rise_c;
  logic                act_is_p1_c, act_rise_c, core_result_c;
  logic [LETTER_W-1:0] act_letter_c;
  fwd_t                req_c;

  state_e              state_q, state_d;
  logic                core_resetn_q, core_resetn_d;
  logic                core_confirm_q, core_confirm_d;
  logic [LETTER_W-1:0] core_letter_q, core_letter_d;
  fwd_t                pend_q, pend_d;
  logic                setter_q, setter_d;
  logic [SCORE_W-1:0]  score0_q, score0_d, score1_q, score1_d, round_q, round_d;
  logic                match_done_q, match_done_d;
  logic [1:0]          winner_q, winner_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                res_win_q, res_win_d;

`ifdef HANGMAN_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmo_c;
`endif

  hangman_edge_sync u_sync_p0 (
    .clock    (clock),
    .Resetn   (Resetn),
    .async_in (p0_confirm),
    .rise_c   (p0_rise_c)
  );

  hangman_edge_sync u_sync_p1 (
    .clock    (clock),
    .Resetn   (Resetn),
    .async_in (p1_confirm),
    .rise_c   (p1_rise_c)
  );

  assign core_result_c = core.core_win | core.core_lose;

  // Setter owns the buttons in SET, the other player in GUESS.
  always_comb begin
    act_is_p1_c  = (state_q == GUESS) ? ~setter_q : setter_q;
    act_rise_c   = act_is_p1_c ? p1_rise_c : p0_rise_c;
    act_letter_c = act_is_p1_c ? p1_letter : p0_letter;
    req_c.letter = act_letter_c;
    req_c.vld    = act_rise_c && letter_ok(act_letter_c) &&
                   ((state_q == SET) || ((state_q == GUESS) && !core_result_c));
`ifdef HANGMAN_TIMEOUT_EN
    if (!req_c.vld && tmo_c) req_c = '{vld: 1'b1, letter: FORCED_MISS};
`endif
  end

  always_comb begin
    state_d        = state_q;
    core_confirm_d = 1'b0;
    core_letter_d  = core_letter_q;
    pend_d         = pend_q;
    setter_d       = setter_q;
    score0_d       = score0_q;
    score1_d       = score1_q;
    round_d        = round_q;
    match_done_d   = match_done_q;
    winner_d       = winner_q;
    cnt_d          = cnt_q;
    res_win_d      = res_win_q;

    case (state_q)
      IDLE:   if (p0_rise_c || p1_rise_c) state_d = CLR;
      CLR: begin
        cnt_d   = '0;
        state_d = SET;
      end
      SET: if (req_c.vld) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 3'(WORD_PULSES - 1)) state_d = GUESS;
      end
      GUESS: if (core_result_c) begin
        res_win_d = core.core_win;
        state_d   = RESULT;
      end
      RESULT: begin
        // A win scores for the guesser (~setter), a loss for the setter.
        if (res_win_q ^ setter_q) score1_d = sat_inc(score1_q);
        else                      score0_d = sat_inc(score0_q);
        if (round_q == SCORE_W'(ROUNDS)) begin
          state_d = DONE;
        end else begin
          round_d  = round_q + 1'b1;
          setter_d = ~setter_q;
          state_d  = CLR;
        end
      end
      DONE:    ;
      default: state_d = IDLE;
    endcase

    if (state_d == DONE) begin
      match_done_d = 1'b1;
      winner_d     = match_winner(score0_d, score1_d);
    end

    // Keep a cycle gap between core confirms; a colliding request waits one cycle.
    if ((state_q == SET) || (state_q == GUESS)) begin
      if (core_confirm_q) begin
        if (req_c.vld) pend_d = req_c;
      end else if (pend_q.vld) begin
        core_confirm_d = 1'b1;
        core_letter_d  = pend_q.letter;
        pend_d         = req_c;
      end else if (req_c.vld) begin
        core_confirm_d = 1'b1;
        core_letter_d  = req_c.letter;
      end
    end else begin
      pend_d = '0;
    end

    core_resetn_d = (state_d != CLR);
  end

`ifdef HANGMAN_TIMEOUT_EN
  assign tmo_c = (state_q == GUESS) && !core_result_c &&
                 (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

  // Guess-idle timer restarts on every letter sent to the core.
  always_comb begin
    tmr_d = tmr_q + 1'b1;
    if ((state_q != GUESS) || core_confirm_d) tmr_d = '0;
  end

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) tmr_q <= '0;
    else         tmr_q <= tmr_d;
  end
`else
  // Parameter has no effect when the timeout is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q        <= IDLE;
      core_resetn_q  <= 1'b0;
      core_confirm_q <= 1'b0;
      core_letter_q  <= '0;
      pend_q         <= '0;
      setter_q       <= 1'b0;
      score0_q       <= '0;
      score1_q       <= '0;
      round_q        <= SCORE_W'(1);
      match_done_q   <= 1'b0;
      winner_q       <= 2'b00;
      cnt_q          <= '0;
      res_win_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      core_resetn_q  <= core_resetn_d;
      core_confirm_q <= core_confirm_d;
      core_letter_q  <= core_letter_d;
      pend_q         <= pend_d;
      setter_q       <= setter_d;
      score0_q       <= score0_d;
      score1_q       <= score1_d;
      round_q        <= round_d;
      match_done_q   <= match_done_d;
      winner_q       <= winner_d;
      cnt_q          <= cnt_d;
      res_win_q      <= res_win_d;
    end
  end

  assign core.core_resetn  = core_resetn_q;
  assign core.core_confirm = core_confirm_q;
  assign core.core_letter  = core_letter_q;
  assign setter            = setter_q;
  assign score0            = score0_q;
  assign score1            = score1_q;
  assign round             = round_q;
  assign match_done        = match_done_q;
  assign winner            = winner_q;

endmodule
